// File: rtl/noc_local_inject_scheduler_if.sv
// Client-side and router-side signals of the local injection scheduler.
//   cli_valid_i/cli_data_i/cli_addr_i/cli_ready_o : per-client flit handshake, packed by client
//   inj_valid_o/inj_data_o/inj_addr_o/inj_ready_i : single flit stream into the router local port
//   grant_o / busy_o                              : current owner (one-hot) and SERVE indication
// slave  : the scheduler
// master : the environment (clients + router)
interface noc_local_inject_scheduler_if #(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 8
);
  logic [NUM_CLIENTS-1:0]            cli_valid_i;
  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cli_data_i;
  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cli_addr_i;
  logic [NUM_CLIENTS-1:0]            cli_ready_o;
  logic                              inj_valid_o;
  logic [DATA_WIDTH-1:0]             inj_data_o;
  logic [ADDR_WIDTH-1:0]             inj_addr_o;
  logic                              inj_ready_i;
  logic [NUM_CLIENTS-1:0]            grant_o;
  logic                              busy_o;

  modport slave (
    input  cli_valid_i, cli_data_i, cli_addr_i, inj_ready_i,
    output cli_ready_o, inj_valid_o, inj_data_o, inj_addr_o, grant_o, busy_o
  );

  modport master (
    output cli_valid_i, cli_data_i, cli_addr_i, inj_ready_i,
    input  cli_ready_o, inj_valid_o, inj_data_o, inj_addr_o, grant_o, busy_o
  );
endinterface

// File: rtl/noc_local_inject_scheduler.sv
// Round-robin injection scheduler sharing one router local input port among NUM_CLIENTS
// requesters. One client owns the port at a time and may push up to MAX_BURST flits into a
// one-entry output register before ownership rotates.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : noc_local_inject_scheduler_if.slave (client handshakes, injection stream,
//                grant_o one-hot owner, busy_o high while serving)
module noc_local_inject_scheduler #(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned MAX_BURST   = 4
) (
  input logic                       clk,
  input logic                       rst_n,
  noc_local_inject_scheduler_if.slave bus
);

  localparam int unsigned IdxW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {StIdle, StServe} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       owner_q, owner_d;
  logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]       burst_cnt_q, burst_cnt_d;
  logic                  inj_valid_q, inj_valid_d;
  logic [DATA_WIDTH-1:0] inj_data_q, inj_data_d;
  logic [ADDR_WIDTH-1:0] inj_addr_q, inj_addr_d;

  logic [DATA_WIDTH-1:0]  cli_data [NUM_CLIENTS];
  logic [ADDR_WIDTH-1:0]  cli_addr [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0] cli_ready;
  logic [NUM_CLIENTS-1:0] grant;
  logic                   slot_free;
  logic                   owner_valid;
  logic                   accept;
  logic                   last_beat;
  logic                   pick_found;
  logic [IdxW-1:0]        pick_idx;
  logic [IdxW-1:0]        owner_next;

  for (genvar c = 0; c < NUM_CLIENTS; c++) begin : g_unpack
    assign cli_data[c] = bus.cli_data_i[c*DATA_WIDTH +: DATA_WIDTH];
    assign cli_addr[c] = bus.cli_addr_i[c*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Output slot can take a new flit if empty or emptying this cycle.
  assign slot_free   = !inj_valid_q || bus.inj_ready_i;
  assign owner_valid = bus.cli_valid_i[owner_q];
  assign accept      = (state_q == StServe) && owner_valid && slot_free;
  // This accept brings the burst count up to MAX_BURST.
  assign last_beat   = (burst_cnt_q == CntW'(MAX_BURST - 1));
  assign owner_next  = IdxW'((32'(owner_q) + 32'd1) % NUM_CLIENTS);

  // First requester scanning circularly from rr_ptr.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      if (!pick_found && bus.cli_valid_i[IdxW'((32'(rr_ptr_q) + i) % NUM_CLIENTS)]) begin
        pick_found = 1'b1;
        pick_idx   = IdxW'((32'(rr_ptr_q) + i) % NUM_CLIENTS);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    inj_valid_d = inj_valid_q;
    inj_data_d  = inj_data_q;
    inj_addr_d  = inj_addr_q;
    cli_ready   = '0;

    // Drain happens in any state; a same-cycle load below overrides it.
    if (inj_valid_q && bus.inj_ready_i) begin
      inj_valid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d     = StServe;
          owner_d     = pick_idx;
          burst_cnt_d = '0;
        end
      end
      StServe: begin
        cli_ready[owner_q] = slot_free;
        if (accept) begin
          inj_valid_d = 1'b1;
          inj_data_d  = cli_data[owner_q];
          inj_addr_d  = cli_addr[owner_q];
          burst_cnt_d = burst_cnt_q + 1'b1;
          if (last_beat) begin
            state_d  = StIdle;
            rr_ptr_d = owner_next;
          end
        end else if (!owner_valid) begin
          // Owner has nothing more to send: give up the port.
          state_d  = StIdle;
          rr_ptr_d = owner_next;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    grant = '0;
    if (state_q == StServe) begin
      grant[owner_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      inj_valid_q <= 1'b0;
      inj_data_q  <= '0;
      inj_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      inj_valid_q <= inj_valid_d;
      inj_data_q  <= inj_data_d;
      inj_addr_q  <= inj_addr_d;
    end
  end

  assign bus.cli_ready_o = cli_ready;
  assign bus.inj_valid_o = inj_valid_q;
  assign bus.inj_data_o  = inj_data_q;
  assign bus.inj_addr_o  = inj_addr_q;
  assign bus.grant_o     = grant;
  assign bus.busy_o      = (state_q == StServe);

endmodule

// File: tb/tb_noc_local_inject_scheduler.sv
// Randomized and directed bench for noc_local_inject_scheduler. A transaction-level model
// (owner/pointer/burst as integers, accepted flits kept in a FIFO scoreboard) predicts every
// output each cycle.
module tb_noc_local_inject_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned MB = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  noc_local_inject_scheduler_if #(
    .NUM_CLIENTS(N),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) bus ();

  noc_local_inject_scheduler #(
    .NUM_CLIENTS(N),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MAX_BURST  (MB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Model state
  int unsigned   seq [N];
  logic [DW-1:0] exp_q [$];
  bit            m_serve;
  int unsigned   m_owner;
  int unsigned   m_rr;
  int unsigned   m_cnt;
  bit            m_vld;
  logic [DW-1:0] m_data;
  logic [AW-1:0] m_addr;
  logic [N-1:0]  last_acc;

  logic [N-1:0] rr_req  [3] = '{4'b1001, 4'b0001, 4'b0010};
  logic [N-1:0] rr_want [3] = '{4'b1000, 4'b0001, 4'b0010};
  int unsigned  acc_want [6] = '{1, 2, 3, 4, 6, 7};

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] payload(input int unsigned c, input int unsigned s);
    return {8'(c), 24'(s)};
  endfunction

  function automatic logic [AW-1:0] addr_of(input int unsigned c, input int unsigned s);
    return AW'(c * 61 + s * 7);
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    r = '0;
    if (m_serve && (!m_vld || bus.inj_ready_i)) r = N'(1) << m_owner;
    return r;
  endfunction

  task automatic model_step(input logic [N-1:0] v, input logic rdy);
    bit free;
    bit found;
    free  = !m_vld || rdy;
    found = 0;
    if (m_vld && rdy) m_vld = 0;
    if (!m_serve) begin
      for (int k = 0; k < N; k++) begin
        int unsigned c;
        c = (m_rr + k) % N;
        if (!found && v[c]) begin
          found   = 1;
          m_serve = 1;
          m_owner = c;
          m_cnt   = 0;
        end
      end
    end else if (v[m_owner] && free) begin
      m_vld  = 1;
      m_data = payload(m_owner, seq[m_owner]);
      m_addr = addr_of(m_owner, seq[m_owner]);
      exp_q.push_back(m_data);
      seq[m_owner]++;
      m_cnt++;
      if (m_cnt == MB) begin
        m_serve = 0;
        m_rr    = (m_owner + 1) % N;
      end
    end else if (!v[m_owner]) begin
      m_serve = 0;
      m_rr    = (m_owner + 1) % N;
    end
  endtask

  task automatic drive_payloads();
    for (int c = 0; c < N; c++) begin
      bus.cli_data_i[c*DW +: DW] = payload(c, seq[c]);
      bus.cli_addr_i[c*AW +: AW] = addr_of(c, seq[c]);
    end
  endtask

  // Entered at posedge+1 with inputs set; leaves at the next posedge+1.
  task automatic cycle();
    logic [N-1:0] v;
    logic         rdy;
    drive_payloads();
    #1;
    check_eq("cli_ready", 64'(bus.cli_ready_o), 64'(exp_ready()));
    v        = bus.cli_valid_i;
    rdy      = bus.inj_ready_i;
    last_acc = bus.cli_ready_o & v;
    if (bus.inj_valid_o && rdy) begin
      check_eq("sb_pending", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) check_eq("sb_order", 64'(bus.inj_data_o), 64'(exp_q.pop_front()));
    end
    @(posedge clk);
    model_step(v, rdy);
    #1;
    check_eq("grant", 64'(bus.grant_o), m_serve ? 64'(N'(1) << m_owner) : 64'(0));
    check_eq("busy", 64'(bus.busy_o), 64'(m_serve));
    check_eq("inj_valid", 64'(bus.inj_valid_o), 64'(m_vld));
    check_eq("inj_data", 64'(bus.inj_data_o), 64'(m_data));
    check_eq("inj_addr", 64'(bus.inj_addr_o), 64'(m_addr));
  endtask

  // Asserts reset mid-cycle and checks outputs clear before any clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    bus.cli_valid_i = '0;
    #1;
    check_eq("rst_inj_valid", 64'(bus.inj_valid_o), 64'(0));
    check_eq("rst_inj_data", 64'(bus.inj_data_o), 64'(0));
    check_eq("rst_inj_addr", 64'(bus.inj_addr_o), 64'(0));
    check_eq("rst_grant", 64'(bus.grant_o), 64'(0));
    check_eq("rst_busy", 64'(bus.busy_o), 64'(0));
    check_eq("rst_cli_ready", 64'(bus.cli_ready_o), 64'(0));
    m_serve = 0;
    m_owner = 0;
    m_rr    = 0;
    m_cnt   = 0;
    m_vld   = 0;
    m_data  = '0;
    m_addr  = '0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0]  prev_g;
    logic [N-1:0]  gseq [5];
    int unsigned   glen [5];
    int unsigned   gi;
    int unsigned   acc_cyc [$];
    int unsigned   base;
    logic [DW-1:0] d0;
    logic [AW-1:0] a0;
    int unsigned   pv;
    int unsigned   pr;

    for (int c = 0; c < N; c++) seq[c] = 0;
    bus.cli_valid_i = '0;
    bus.cli_data_i  = '0;
    bus.cli_addr_i  = '0;
    bus.inj_ready_i = 1'b0;
    last_acc        = '0;
    #2;
    do_reset();

    // Client 0 streams 6 flits with the router always ready.
    bus.inj_ready_i = 1'b1;
    base = seq[0];
    for (int k = 0; k < 10; k++) begin
      bus.cli_valid_i = ((seq[0] - base) < 6) ? 4'b0001 : 4'b0000;
      cycle();
      if (last_acc[0]) acc_cyc.push_back(k);
    end
    check_eq("stream_n_acc", 64'(acc_cyc.size()), 64'(6));
    for (int i = 0; i < 6; i++) begin
      if (i < acc_cyc.size()) check_eq("stream_acc_cycle", 64'(acc_cyc[i]), 64'(acc_want[i]));
    end

    // All clients requesting continuously: rotation and burst length.
    do_reset();
    bus.inj_ready_i = 1'b1;
    prev_g = '0;
    gi     = 0;
    for (int i = 0; i < 5; i++) begin
      gseq[i] = '0;
      glen[i] = 0;
    end
    for (int k = 0; k < 25; k++) begin
      bus.cli_valid_i = '1;
      cycle();
      if (bus.grant_o != 0 && prev_g == 0 && gi < 5) begin
        gseq[gi] = bus.grant_o;
        gi++;
      end
      if (bus.grant_o != 0 && gi > 0) glen[gi-1]++;
      prev_g = bus.grant_o;
    end
    for (int i = 0; i < 5; i++) check_eq("rot_grant", 64'(gseq[i]), 64'(N'(1) << (i % N)));
    for (int i = 0; i < 4; i++) check_eq("rot_burst_len", 64'(glen[i]), 64'(MB));
    bus.cli_valid_i = '0;
    for (int k = 0; k < 3; k++) cycle();

    // Client 1 owns while the router stalls for 5 cycles.
    do_reset();
    bus.inj_ready_i = 1'b1;
    bus.cli_valid_i = 4'b0010;
    cycle();
    cycle();
    check_eq("stall_pre_vld", 64'(bus.inj_valid_o), 64'(1));
    bus.inj_ready_i = 1'b0;
    d0 = bus.inj_data_o;
    a0 = bus.inj_addr_o;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check_eq("stall_data", 64'(bus.inj_data_o), 64'(d0));
      check_eq("stall_addr", 64'(bus.inj_addr_o), 64'(a0));
      check_eq("stall_busy", 64'(bus.busy_o), 64'(1));
      check_eq("stall_no_acc", 64'(last_acc), 64'(0));
    end
    bus.inj_ready_i = 1'b1;
    cycle();
    check_eq("release_acc", 64'(last_acc), 64'(4'b0010));
    bus.cli_valid_i = '0;
    for (int k = 0; k < 3; k++) cycle();

    // Client 2 drops after 2 accepts, leaving the pointer at 3.
    for (int t = 0; t < 3; t++) begin
      do_reset();
      bus.inj_ready_i = 1'b1;
      base = seq[2];
      for (int k = 0; k < 5; k++) begin
        bus.cli_valid_i = ((seq[2] - base) < 2) ? 4'b0100 : 4'b0000;
        cycle();
      end
      check_eq("drop_n_acc", 64'(seq[2] - base), 64'(2));
      check_eq("drop_idle", 64'(bus.grant_o), 64'(0));
      bus.cli_valid_i = rr_req[t];
      cycle();
      check_eq("rr_grant", 64'(bus.grant_o), 64'(rr_want[t]));
      bus.cli_valid_i = '0;
      for (int k = 0; k < 3; k++) cycle();
    end

    // Reset mid-burst with a flit pending.
    do_reset();
    bus.inj_ready_i = 1'b1;
    bus.cli_valid_i = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      if (!bus.inj_valid_o) cycle();
    end
    check_eq("mid_rst_pending", 64'(bus.inj_valid_o), 64'(1));
    do_reset();
    bus.cli_valid_i = '1;
    cycle();
    check_eq("post_rst_grant", 64'(bus.grant_o), 64'(4'b0001));

    // Randomized traffic and back-pressure.
    for (int blk = 0; blk < 10; blk++) begin
      pv = $urandom_range(100, 20);
      pr = $urandom_range(100, 20);
      if (blk == 5) do_reset();
      for (int k = 0; k < 200; k++) begin
        for (int c = 0; c < N; c++) bus.cli_valid_i[c] = ($urandom_range(99, 0) < pv);
        bus.inj_ready_i = ($urandom_range(99, 0) < pr);
        cycle();
      end
    end

    // Drain: everything accepted must have left in order.
    bus.cli_valid_i = '0;
    bus.inj_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) cycle();
    check_eq("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
